note_div_engine: RTL and testbench
==================================

Name: note_div_engine

Overview:
- Multi-channel, time-multiplexed converter from raw tone frequency to the note_gen half-period divider.
- Computes DIVIDEND / (freq shifted by octave) with one shared iterative restoring divider, one quotient bit per cycle.
- Replaces the per-channel combinational 32-bit divides in the top level.
- Sits between the music/tone source and note_gen. Each channel refreshes every CHANNELS*(DVD_W+2) cycles, which is negligible against the beat clock.

Parameters:
- CHANNELS, 2, number of independent tone channels (ch0 = left, ch1 = right).
- FREQ_W, 32, width of each raw frequency input.
- DIV_W, 22, width of each divider output.
- DIVIDEND, 100000000, numerator (clk Hz).
- SILENCE, 100000000, raw frequency code meaning "no tone".
- OCT_CENTER, 2, octave code that applies no shift.
- OCT_SPAN, 2, maximum shift in octaves either side of OCT_CENTER.
- Derived localparam: DVD_W = bits needed to hold DIVIDEND (27 for the default).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous active-high reset
- freq_in  in  CHANNELS*FREQ_W  raw frequencies; channel k occupies bits [k*FREQ_W +: FREQ_W]
- octave  in  3  global octave code, shared by all channels
- enable  in  1  when 0, the scanner finishes the current channel, then parks in IDLE; outputs hold
- div_out  out  CHANNELS*DIV_W  registered divider per channel; channel k occupies bits [k*DIV_W +: DIV_W]
- upd  out  CHANNELS  one-cycle strobe; bit k pulses in the same cycle that div_out for channel k changes register value
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1), in any state including mid-divide:
  - every div_out field = 1 (silent), upd = 0, busy = 0;
  - state = IDLE, channel pointer = 0, divider registers cleared.
- FSM states: IDLE, LOAD, DIV, WRITE.
- IDLE:
  - if enable = 1, go to LOAD next cycle; otherwise stay in IDLE.
- LOAD (1 cycle):
  - latch freq_in[ptr] and octave into working registers. Input changes after this cycle affect only the next pass.
  - Effective frequency f_eff, computed at width FREQ_W+OCT_SPAN:
    - octave in [OCT_CENTER-OCT_SPAN, OCT_CENTER-1]: f_eff = f >> (OCT_CENTER-octave), truncating;
    - octave in [OCT_CENTER+1, OCT_CENTER+OCT_SPAN]: f_eff = f << (octave-OCT_CENTER), no overflow possible;
    - any other octave (including OCT_CENTER and out-of-range codes): f_eff = f.
  - Silent case: raw f == SILENCE, raw f == 0, or f_eff == 0. Result = 1 and the FSM goes straight to WRITE; the divider is skipped.
  - Any other f_eff: remainder = 0, quotient = 0, bit counter = DVD_W-1; go to DIV.
- DIV (exactly DVD_W cycles, MSB-first restoring division):
  - remainder = (remainder << 1) | DIVIDEND[bit];
  - if remainder >= f_eff: subtract f_eff and set quotient[bit];
  - leave for WRITE after bit 0.
- WRITE (1 cycle):
  - result = quotient saturated to 2^DIV_W-1 if quotient exceeds DIV_W bits;
  - a quotient of 0 (f_eff > DIVIDEND) is written as 1;
  - div_out[ptr] <= result; upd[ptr] = 1 only if result differs from the old div_out[ptr];
  - ptr <= (ptr == CHANNELS-1) ? 0 : ptr+1;
  - next state is LOAD if enable = 1, else IDLE.
- Latency per channel:
  - non-silent: DVD_W+2 cycles (29 for the default), from LOAD to div_out updated;
  - silent: 2 cycles.
- Round-robin order ch0, ch1, ..., ch(CHANNELS-1), wrapping to ch0. There is no priority and no skipping.
- upd is never asserted on more than one bit per cycle.
- busy = 1 in LOAD, DIV and WRITE.
- div_out registers change only in WRITE or at reset, so they are glitch-free toward note_gen.
- Deasserting enable mid-DIV never truncates a division; the current channel completes and is written.

Test Plan:
1. Reset:
   - assert rst for 3 cycles, enable = 0 -> every div_out field = 1, upd = 0, busy = 0;
   - assert rst mid-DIV -> same values appear immediately (asynchronously).
2. Nominal:
   - ch0 = 440, ch1 = 262, octave = 2, enable = 1;
   - -> ch0 = 227272 written 29 cycles after the first LOAD, ch1 = 381679 written 29 cycles later;
   - -> each write is accompanied by a single upd pulse for that channel.
3. Octave:
   - ch0 = 440 with octave = 3 -> 113636; octave = 4 -> 56818; octave = 1 -> 454545; octave = 0 -> 909090; octave = 7 -> 227272.
4. Silence and zero:
   - ch0 = 100000000 -> 1 within 2 cycles of its LOAD, no divide;
   - ch0 = 0 -> 1;
   - ch0 = 1 with octave = 0 (f_eff = 0) -> 1;
   - in all three cases busy returns to the round-robin with no hang.
5. Saturation:
   - ch0 = 10, octave = 2 -> quotient 10000000 > 4194303 -> div_out = 4194303;
   - ch0 = 200000000 -> 1.
6. Enable and mid-op input change:
   - change freq_in[0] from 440 to 880 during ch0's DIV -> 227272 is written first, then 113636 on the next ch0 pass;
   - drop enable during DIV -> that channel's write still occurs, then IDLE with busy = 0 and outputs held;
   - no upd pulse is issued when a rewrite leaves the value unchanged.

Source files
------------

// File: rtl/note_div_engine.sv
// -----------------------------------------------------------------------------
// note_div_engine
//
// Time-multiplexed converter from raw tone frequency to the half-period
// divider consumed by note_gen. One shared restoring divider computes
// DIVIDEND / f_eff for each channel in turn, one quotient bit per cycle, where
// f_eff is the raw channel frequency shifted by the global octave code.
//
// Channels are serviced round-robin (ch0, ch1, ..., wrap). A non-silent
// channel takes DVD_W+2 cycles from LOAD to its div_out update. A silent
// channel takes 2 cycles.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   freq_in      raw frequencies, channel k at [k*FREQ_W +: FREQ_W]
//   octave       global octave code (OCT_CENTER = no shift)
//   enable       1: keep scanning; 0: finish current channel, then park in IDLE
//   div_out      registered divider per channel, channel k at [k*DIV_W +: DIV_W]
//   upd          one-cycle strobe, bit k high when div_out field k changed value
//   busy         high whenever the scanner is not parked in IDLE
//   dbg_state_o  current FSM state (IDLE=0, LOAD=1, DIV=2, WRITE=3)
//
// Handshake: there is no valid/ready pair. upd is a pure notification, and it
// is raised in the same cycle in which the matching div_out field changes.
// -----------------------------------------------------------------------------
module note_div_engine #(
    parameter int CHANNELS   = 2,
    parameter int FREQ_W     = 32,
    parameter int DIV_W      = 22,
    parameter int DIVIDEND   = 100000000,
    parameter int SILENCE    = 100000000,
    parameter int OCT_CENTER = 2,
    parameter int OCT_SPAN   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*FREQ_W-1:0] freq_in,
    input  logic [2:0]                 octave,
    input  logic                       enable,
    output logic [CHANNELS*DIV_W-1:0]  div_out,
    output logic [CHANNELS-1:0]        upd,
    output logic                       busy,
    output logic [1:0]                 dbg_state_o
);

    // ------------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------------
    localparam int DVD_W = $clog2(DIVIDEND + 1);          // bits of the numerator
    localparam int FE_W  = FREQ_W + OCT_SPAN;             // room for f << OCT_SPAN
    localparam int BIT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int QW    = (DVD_W > DIV_W) ? DVD_W : DIV_W;

    localparam logic [DVD_W-1:0]  DVD_VEC = DVD_W'(DIVIDEND);
    localparam logic [FREQ_W-1:0] SIL_VEC = FREQ_W'(SILENCE);
    localparam logic [DIV_W-1:0]  DIV_MAX = '1;
    localparam logic [DIV_W-1:0]  DIV_ONE = DIV_W'(1);
    localparam logic [PTR_W-1:0]  LAST_CH = PTR_W'(CHANNELS - 1);
    localparam logic [BIT_W-1:0]  TOP_BIT = BIT_W'(DVD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DIV   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                      state_q;
    logic [PTR_W-1:0]            ptr_q;
    logic [FE_W-1:0]             f_eff_q;   // divisor for the channel in flight
    logic [FE_W-1:0]             rem_q;     // partial remainder, always < f_eff_q
    logic [DVD_W-1:0]            quot_q;
    logic [BIT_W-1:0]            bit_q;     // numerator bit consumed next in DIV
    logic [CHANNELS*DIV_W-1:0]   div_out_q;
    logic [CHANNELS-1:0]         upd_q;
    logic                        busy_q;

    // ------------------------------------------------------------------------
    // LOAD: select the current channel and apply the octave shift
    // ------------------------------------------------------------------------
    int                 ld_base;
    int                 oct_s;
    logic [FREQ_W-1:0]  ld_freq;
    logic [FE_W-1:0]    ld_feff;
    logic               ld_silent;

    always_comb begin
        ld_base = int'(ptr_q) * FREQ_W;
        oct_s   = int'(octave);
        ld_freq = freq_in[ld_base +: FREQ_W];
        // Codes outside the shift window (including OCT_CENTER) leave f as is.
        ld_feff = FE_W'(ld_freq);
        for (int k = 1; k <= OCT_SPAN; k++) begin
            if (oct_s == OCT_CENTER - k) begin
                ld_feff = FE_W'(ld_freq) >> k;
            end
            if (oct_s == OCT_CENTER + k) begin
                ld_feff = FE_W'(ld_freq) << k;
            end
        end
        // A downshift can truncate a tiny frequency to zero; treat as silence
        // rather than dividing by zero.
        ld_silent = (ld_freq == SIL_VEC) || (ld_freq == '0) || (ld_feff == '0);
    end

    // ------------------------------------------------------------------------
    // DIV: one restoring-division step
    // ------------------------------------------------------------------------
    logic [FE_W:0]    rem_shift;
    logic [FE_W-1:0]  rem_next;
    logic             q_bit;

    always_comb begin
        rem_shift = {rem_q, DVD_VEC[bit_q]};
        q_bit     = (rem_shift >= {1'b0, f_eff_q});
        // Without a subtract the shifted value is below f_eff_q, so the top
        // bit is zero and dropping it is lossless.
        if (q_bit) begin
            rem_next = FE_W'(rem_shift - {1'b0, f_eff_q});
        end else begin
            rem_next = rem_shift[FE_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // WRITE: saturate the quotient and compare against the stored value
    // ------------------------------------------------------------------------
    int               wr_base;
    logic [QW-1:0]    q_ext;
    logic [DIV_W-1:0] wr_val;
    logic [DIV_W-1:0] old_val;

    always_comb begin
        wr_base = int'(ptr_q) * DIV_W;
        q_ext   = QW'(quot_q);
        old_val = div_out_q[wr_base +: DIV_W];
        if (q_ext > QW'(DIV_MAX)) begin
            wr_val = DIV_MAX;
        end else if (q_ext == '0) begin
            // f_eff above DIVIDEND: a zero divider would stall note_gen.
            wr_val = DIV_ONE;
        end else begin
            wr_val = DIV_W'(q_ext);
        end
    end

    // ------------------------------------------------------------------------
    // FSM and all registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            f_eff_q   <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            bit_q     <= '0;
            div_out_q <= {CHANNELS{DIV_ONE}};
            upd_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            upd_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end

                S_LOAD: begin
                    // Only the shifted divisor is kept; later input changes
                    // wait for this channel's next pass.
                    f_eff_q <= ld_feff;
                    rem_q   <= '0;
                    bit_q   <= TOP_BIT;
                    if (ld_silent) begin
                        quot_q  <= DVD_W'(1);
                        state_q <= S_WRITE;
                    end else begin
                        quot_q  <= '0;
                        state_q <= S_DIV;
                    end
                end

                S_DIV: begin
                    rem_q         <= rem_next;
                    quot_q[bit_q] <= q_bit;
                    if (bit_q == '0) begin
                        state_q <= S_WRITE;
                    end else begin
                        bit_q <= bit_q - BIT_W'(1);
                    end
                end

                S_WRITE: begin
                    div_out_q[wr_base +: DIV_W] <= wr_val;
                    upd_q[ptr_q]                <= (wr_val != old_val);
                    ptr_q <= (ptr_q == LAST_CH) ? '0 : ptr_q + PTR_W'(1);
                    // enable is only sampled here, so a running divide always
                    // completes and is written before the scanner parks.
                    if (enable) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div_out     = div_out_q;
    assign upd         = upd_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_note_div_engine.sv
// -----------------------------------------------------------------------------
// tb_note_div_engine
//
// Self-checking bench for note_div_engine. The bench keeps its own cursor:
// every scenario task positions itself just after the edge on which a channel
// enters LOAD, then steps that channel for its known latency, checking that
// outputs hold until the write and change exactly on it.
// -----------------------------------------------------------------------------
module tb_note_div_engine;

    localparam int          CH       = 2;
    localparam int          FW       = 32;
    localparam int          DW       = 22;
    localparam longint      DIVIDEND = 100000000;
    localparam logic [31:0] SILENCE  = 32'd100000000;
    localparam logic [21:0] MAXV     = 22'h3FFFFF;
    localparam int          LAT_DIV  = 29;
    localparam int          LAT_SIL  = 2;

    // ------------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------------
    logic               clk;
    logic               rst;
    logic [CH*FW-1:0]   freq_in;
    logic [2:0]         octave;
    logic               enable;
    logic [CH*DW-1:0]   div_out;
    logic [CH-1:0]      upd;
    logic               busy;
    logic [1:0]         dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    note_div_engine dut (
        .clk         (clk),
        .rst         (rst),
        .freq_in     (freq_in),
        .octave      (octave),
        .enable      (enable),
        .div_out     (div_out),
        .upd         (upd),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    int              total = 0;
    int              bad   = 0;
    logic [DW-1:0]   exp_out [CH];
    logic [DW-1:0]   exp_q [$];
    int              next_ch;

    // Reference: plain integer arithmetic on the frequency/octave rules.
    function automatic logic [DW-1:0] ref_div(input logic [FW-1:0] f,
                                              input logic [2:0] oct,
                                              output int lat);
        longint fe;
        longint q;
        int     o;
        o  = int'(oct);
        fe = longint'({32'd0, f});
        if (o == 0 || o == 1) fe = fe >> (2 - o);
        else if (o == 3 || o == 4) fe = fe << (o - 2);
        if (f == SILENCE || f == 0 || fe == 0) begin
            lat = LAT_SIL;
            return DW'(1);
        end
        lat = LAT_DIV;
        q = DIVIDEND / fe;
        if (q > longint'(MAXV)) q = longint'(MAXV);
        if (q == 0) q = 1;
        return DW'(q);
    endfunction

    function automatic logic [CH*DW-1:0] packed_exp();
        logic [CH*DW-1:0] v;
        for (int k = 0; k < CH; k++) v[k*DW +: DW] = exp_out[k];
        return v;
    endfunction

    // upd must never carry more than one bit.
    always @(negedge clk) begin
        total++;
        if ($countones(upd) > 1) begin
            bad++;
            $display("FAIL upd_onehot: got %b required at most one bit", upd);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic set_freq(input int ch, input logic [FW-1:0] f);
        freq_in[ch*FW +: FW] = f;
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < CH; k++) exp_out[k] = DW'(1);
        next_ch = 0;
    endtask

    // From IDLE: raise enable and land just after the LOAD entry edge.
    task automatic start_engine();
        enable = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy: got %b required 1", busy);
        end
    endtask

    // Step one channel from its LOAD entry to its write. change_at / drop_at
    // are cycle indices (1 = just after the latch edge) at which the channel
    // frequency is changed or enable dropped; -1 disables them.
    task automatic step_channel(input int ch, input logic [DW-1:0] exp_v,
                                input int lat, input int change_at,
                                input logic [FW-1:0] new_f, input int drop_at);
        logic [DW-1:0]    old;
        logic [CH-1:0]    upd_exp;
        logic [CH*DW-1:0] pv;
        old = exp_out[ch];
        for (int i = 1; i < lat; i++) begin
            @(posedge clk);
            #1;
            pv = packed_exp();
            total++;
            if (div_out !== pv || upd !== '0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL hold_ch%0d_cyc%0d: got div=%h upd=%b busy=%b required div=%h upd=0 busy=1",
                         ch, i, div_out, upd, busy, pv);
            end
            if (i == change_at) set_freq(ch, new_f);
            if (i == drop_at) enable = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_out[ch] = exp_v;
        pv      = packed_exp();
        upd_exp = (exp_v != old) ? (CH'(1) << ch) : '0;
        total++;
        if (div_out !== pv) begin
            bad++;
            $display("FAIL write_ch%0d: got %0d required %0d", ch,
                     div_out[ch*DW +: DW], exp_v);
        end
        total++;
        if (upd !== upd_exp) begin
            bad++;
            $display("FAIL upd_ch%0d: got %b required %b", ch, upd, upd_exp);
        end
        total++;
        if (busy !== enable) begin
            bad++;
            $display("FAIL busy_after_write_ch%0d: got %b required %b", ch, busy, enable);
        end
        next_ch = (ch + 1) % CH;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        octave = 3'd2;
        set_freq(0, 32'd440);
        set_freq(1, 32'd262);
        reset_dut();
        total++;
        if (div_out !== packed_exp() || upd !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: got div=%h upd=%b busy=%b required div=%h upd=0 busy=0",
                     div_out, upd, busy, packed_exp());
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if (busy !== 1'b0 || upd !== '0) begin
                bad++;
                $display("FAIL idle_hold: got busy=%b upd=%b required 0 0", busy, upd);
            end
        end
    endtask

    task automatic test_nominal();
        octave = 3'd2;
        set_freq(0, 32'd440);
        set_freq(1, 32'd262);
        reset_dut();
        start_engine();
        step_channel(0, 22'd227272, LAT_DIV, -1, '0, -1);
        step_channel(1, 22'd381679, LAT_DIV, -1, '0, -1);
        // Unchanged rewrite: no upd expected.
        step_channel(0, 22'd227272, LAT_DIV, -1, '0, -1);
        step_channel(1, 22'd381679, LAT_DIV, -1, '0, -1);
        enable = 1'b0;
        repeat (LAT_DIV + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_octave();
        int            oct_tab [5];
        logic [DW-1:0] res_tab [5];
        oct_tab = '{3, 4, 1, 0, 7};
        res_tab = '{22'd113636, 22'd56818, 22'd454545, 22'd909090, 22'd227272};
        octave = 3'd2;
        set_freq(0, 32'd440);
        set_freq(1, SILENCE);
        reset_dut();
        start_engine();
        for (int i = 0; i < 5; i++) begin
            octave = 3'(oct_tab[i]);
            step_channel(0, res_tab[i], LAT_DIV, -1, '0, -1);
            step_channel(1, 22'd1, LAT_SIL, -1, '0, -1);
        end
        octave = 3'd2;
        enable = 1'b0;
        repeat (LAT_DIV + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_silence();
        octave = 3'd2;
        set_freq(0, 32'd440);
        set_freq(1, SILENCE);
        reset_dut();
        start_engine();
        step_channel(0, 22'd227272, LAT_DIV, -1, '0, -1);
        set_freq(0, SILENCE);
        step_channel(1, 22'd1, LAT_SIL, -1, '0, -1);
        step_channel(0, 22'd1, LAT_SIL, -1, '0, -1);
        set_freq(0, 32'd440);
        step_channel(1, 22'd1, LAT_SIL, -1, '0, -1);
        step_channel(0, 22'd227272, LAT_DIV, -1, '0, -1);
        set_freq(0, 32'd0);
        step_channel(1, 22'd1, LAT_SIL, -1, '0, -1);
        step_channel(0, 22'd1, LAT_SIL, -1, '0, -1);
        set_freq(0, 32'd440);
        step_channel(1, 22'd1, LAT_SIL, -1, '0, -1);
        step_channel(0, 22'd227272, LAT_DIV, -1, '0, -1);
        set_freq(0, 32'd1);
        step_channel(1, 22'd1, LAT_SIL, -1, '0, -1);
        octave = 3'd0;
        step_channel(0, 22'd1, LAT_SIL, -1, '0, -1);
        octave = 3'd2;
        step_channel(1, 22'd1, LAT_SIL, -1, '0, -1);
        enable = 1'b0;
        repeat (LAT_DIV + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        octave = 3'd2;
        set_freq(0, 32'd10);
        set_freq(1, 32'd262);
        reset_dut();
        start_engine();
        step_channel(0, MAXV, LAT_DIV, -1, '0, -1);
        step_channel(1, 22'd381679, LAT_DIV, -1, '0, -1);
        set_freq(1, 32'd200000000);
        set_freq(0, 32'd24);
        step_channel(0, 22'd4166666, LAT_DIV, -1, '0, -1);
        step_channel(1, 22'd1, LAT_DIV, -1, '0, -1);
        set_freq(0, 32'd23);
        step_channel(0, MAXV, LAT_DIV, -1, '0, -1);
        enable = 1'b0;
        repeat (LAT_DIV + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_enable_midop();
        octave = 3'd2;
        set_freq(0, 32'd440);
        set_freq(1, 32'd262);
        reset_dut();
        start_engine();
        step_channel(0, 22'd227272, LAT_DIV, 10, 32'd880, -1);
        step_channel(1, 22'd381679, LAT_DIV, -1, '0, -1);
        step_channel(0, 22'd113636, LAT_DIV, -1, '0, -1);
        step_channel(1, 22'd381679, LAT_DIV, -1, '0, 8);
        set_freq(1, 32'd523);
        repeat (10) begin
            @(posedge clk);
            #1;
            total++;
            if (busy !== 1'b0 || upd !== '0 || div_out !== packed_exp()) begin
                bad++;
                $display("FAIL parked_hold: got busy=%b upd=%b div=%h required 0 0 %h",
                         busy, upd, div_out, packed_exp());
            end
        end
        start_engine();
        step_channel(next_ch, 22'd113636, LAT_DIV, -1, '0, -1);
        step_channel(next_ch, 22'd191204, LAT_DIV, -1, '0, -1);
        enable = 1'b0;
        repeat (LAT_DIV + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_div();
        octave = 3'd2;
        set_freq(0, 32'd440);
        set_freq(1, 32'd262);
        reset_dut();
        start_engine();
        step_channel(0, 22'd227272, LAT_DIV, -1, '0, -1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int k = 0; k < CH; k++) exp_out[k] = DW'(1);
        total++;
        if (div_out !== packed_exp() || upd !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got div=%h upd=%b busy=%b required div=%h upd=0 busy=0",
                     div_out, upd, busy, packed_exp());
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        next_ch = 0;
        start_engine();
        step_channel(0, 22'd227272, LAT_DIV, -1, '0, -1);
        enable = 1'b0;
        repeat (LAT_DIV + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [FW-1:0] f;
        logic [2:0]    o;
        int            sel;
        int            lat;
        int            c;
        octave = 3'd2;
        set_freq(0, 32'd440);
        set_freq(1, 32'd262);
        reset_dut();
        start_engine();
        for (int i = 0; i < 24; i++) begin
            c   = next_ch;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       f = 32'd0;
                1:       f = SILENCE;
                2:       f = FW'($urandom_range(1, 30));
                3:       f = FW'($urandom_range(100000001, 400000000));
                default: f = FW'($urandom_range(20, 20000));
            endcase
            o = 3'($urandom_range(0, 7));
            set_freq(c, f);
            octave = o;
            exp_q.push_back(ref_div(f, o, lat));
            step_channel(c, exp_q.pop_front(), lat, -1, '0, -1);
        end
        enable = 1'b0;
        repeat (LAT_DIV + 2) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        octave  = 3'd2;
        freq_in = '0;
        next_ch = 0;
        test_reset();
        test_nominal();
        test_octave();
        test_silence();
        test_saturation();
        test_enable_midop();
        test_reset_mid_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
